udma_l2_port_merge: RTL and testbench

Merges the two uDMA L2 master ports (read-only channel feeding TX peripherals, write-only channel fed by RX peripherals) into a single TCDM master port toward L2 memory. Sits directly downstream of `udma_subsystem`, between its `L2_ro_*` / `L2_wo_*` ports and the L2 interconnect or `tcdm_model`. Arbitrates requests and tracks outstanding grants in an ID FIFO so that in-order responses are routed back to the issuing channel.

---
 rtl/udma_l2_port_merge.sv | 122 ++++++++++++
 tb/tb_udma_l2_port_merge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_l2_port_merge.sv
// Merges the uDMA L2 ro (TX) and wo (RX) master ports onto one TCDM master port.
// Optional round-robin arbitration when UDMA_L2_MERGE_RR_EN is defined; fixed wo-priority otherwise.
module udma_l2_port_merge #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    sys_clk_i,
  input  logic                    sys_resetn_i,

  input  logic                    L2_ro_req_i,
  input  logic                    L2_ro_wen_i,
  input  logic [ADDR_WIDTH-1:0]   L2_ro_addr_i,
  input  logic [DATA_WIDTH/8-1:0] L2_ro_be_i,
  input  logic [DATA_WIDTH-1:0]   L2_ro_wdata_i,
  output logic                    L2_ro_gnt_o,
  output logic                    L2_ro_rvalid_o,
  output logic [DATA_WIDTH-1:0]   L2_ro_rdata_o,

  input  logic                    L2_wo_req_i,
  input  logic                    L2_wo_wen_i,
  input  logic [ADDR_WIDTH-1:0]   L2_wo_addr_i,
  input  logic [DATA_WIDTH/8-1:0] L2_wo_be_i,
  input  logic [DATA_WIDTH-1:0]   L2_wo_wdata_i,
  output logic                    L2_wo_gnt_o,
  output logic                    L2_wo_rvalid_o,
  output logic [DATA_WIDTH-1:0]   L2_wo_rdata_o,

  output logic                    l2_req_o,
  output logic                    l2_wen_o,
  output logic [ADDR_WIDTH-1:0]   l2_addr_o,
  output logic [DATA_WIDTH/8-1:0] l2_be_o,
  output logic [DATA_WIDTH-1:0]   l2_wdata_o,
  input  logic                    l2_gnt_i,
  input  logic                    l2_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   l2_rdata_i,

  output logic                    err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [MAX_OUTSTANDING-1:0] id_fifo;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       full;
  logic                       empty;
  logic                       winner;
  logic                       push;
  logic                       pop;
  logic                       head_id;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

`ifdef UDMA_L2_MERGE_RR_EN
  logic prio_q;

  // prio_q names the channel that wins the next contended cycle (0 = ro, 1 = wo)
  assign winner = (L2_ro_req_i & L2_wo_req_i) ? prio_q : L2_wo_req_i;

  always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
    if (!sys_resetn_i) begin
      prio_q <= 1'b0;
    end else if (push & L2_ro_req_i & L2_wo_req_i) begin
      prio_q <= ~winner;
    end
  end
`else
  // RX data must never be lost, so wo always wins; ro may starve
  assign winner = L2_wo_req_i;
`endif

  // request path: fully combinational, full blocks even when a pop is in flight
  assign l2_req_o   = (L2_ro_req_i | L2_wo_req_i) & ~full;
  assign l2_wen_o   = winner ? L2_wo_wen_i   : L2_ro_wen_i;
  assign l2_addr_o  = winner ? L2_wo_addr_i  : L2_ro_addr_i;
  assign l2_be_o    = winner ? L2_wo_be_i    : L2_ro_be_i;
  assign l2_wdata_o = winner ? L2_wo_wdata_i : L2_ro_wdata_i;

  assign push        = l2_gnt_i & l2_req_o;
  assign L2_ro_gnt_o = push & ~winner;
  assign L2_wo_gnt_o = push &  winner;

  // response path: routed by the oldest outstanding grant ID
  assign head_id        = id_fifo[rd_ptr];
  assign pop            = l2_rvalid_i & ~empty;
  assign L2_ro_rvalid_o = pop & ~head_id;
  assign L2_wo_rvalid_o = pop &  head_id;
  assign L2_ro_rdata_o  = l2_rdata_i;
  assign L2_wo_rdata_o  = l2_rdata_i;

  always_ff @(posedge sys_clk_i) begin
    if (push) begin
      id_fifo[wr_ptr] <= winner;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
    if (!sys_resetn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push & ~pop)      count <= count + CNT_W'(1);
      else if (pop & ~push) count <= count - CNT_W'(1);
      if (l2_rvalid_i & empty) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_udma_l2_port_merge.sv
// Directed bench for udma_l2_port_merge with a queue-based reference model.
module tb_udma_l2_port_merge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          ro_req, ro_wen, wo_req, wo_wen;
  logic [AW-1:0] ro_addr, wo_addr;
  logic [3:0]    ro_be, wo_be;
  logic [DW-1:0] ro_wdata, wo_wdata;
  logic          ro_gnt, ro_rvalid, wo_gnt, wo_rvalid;
  logic [DW-1:0] ro_rdata, wo_rdata;
  logic          l2_req, l2_wen, l2_gnt, l2_rvalid, err;
  logic [AW-1:0] l2_addr;
  logic [3:0]    l2_be;
  logic [DW-1:0] l2_wdata, l2_rdata;

  udma_l2_port_merge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .sys_clk_i(clk), .sys_resetn_i(rst_n),
    .L2_ro_req_i(ro_req), .L2_ro_wen_i(ro_wen), .L2_ro_addr_i(ro_addr), .L2_ro_be_i(ro_be),
    .L2_ro_wdata_i(ro_wdata), .L2_ro_gnt_o(ro_gnt), .L2_ro_rvalid_o(ro_rvalid), .L2_ro_rdata_o(ro_rdata),
    .L2_wo_req_i(wo_req), .L2_wo_wen_i(wo_wen), .L2_wo_addr_i(wo_addr), .L2_wo_be_i(wo_be),
    .L2_wo_wdata_i(wo_wdata), .L2_wo_gnt_o(wo_gnt), .L2_wo_rvalid_o(wo_rvalid), .L2_wo_rdata_o(wo_rdata),
    .l2_req_o(l2_req), .l2_wen_o(l2_wen), .l2_addr_o(l2_addr), .l2_be_o(l2_be), .l2_wdata_o(l2_wdata),
    .l2_gnt_i(l2_gnt), .l2_rvalid_i(l2_rvalid), .l2_rdata_i(l2_rdata), .err_o(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: queue of outstanding channel IDs in grant order
  bit mq[$];
  bit m_prio = 0;
  bit m_err = 0;

  function automatic bit m_winner();
    if (ro_req && wo_req) begin
`ifdef UDMA_L2_MERGE_RR_EN
      return m_prio;
`else
      return 1'b1;
`endif
    end
    return wo_req;
  endfunction

  always @(negedge rst_n) begin
    mq.delete();
    m_prio = 0;
    m_err = 0;
  end

  always @(posedge clk) begin : model_update
    bit w, req, g;
    if (chk_en && rst_n) begin
      w   = m_winner();
      req = (ro_req || wo_req) && (mq.size() != MAXO);
      g   = l2_gnt && req;
      if (l2_rvalid) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else m_err = 1;
      end
      if (g) mq.push_back(w);
      if (g && ro_req && wo_req) m_prio = !w;
    end
  end

  always @(negedge clk) begin : compare
    bit w, req, g, rv;
    if (chk_en) begin
      w   = m_winner();
      req = (ro_req || wo_req) && (mq.size() != MAXO);
      g   = l2_gnt && req;
      rv  = l2_rvalid && (mq.size() > 0);
      chk("l2_req", l2_req, req);
      chk("ro_gnt", ro_gnt, g && !w);
      chk("wo_gnt", wo_gnt, g && w);
      chk("l2_wen", l2_wen, w ? wo_wen : ro_wen);
      chk("l2_addr", l2_addr, w ? wo_addr : ro_addr);
      chk("l2_be", l2_be, w ? wo_be : ro_be);
      chk("l2_wdata", l2_wdata, w ? wo_wdata : ro_wdata);
      chk("ro_rvalid", ro_rvalid, rv && (mq[0] == 1'b0));
      chk("wo_rvalid", wo_rvalid, rv && (mq[0] == 1'b1));
      chk("ro_rdata", ro_rdata, l2_rdata);
      chk("wo_rdata", wo_rdata, l2_rdata);
      chk("err", err, m_err);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    ro_req = 0; wo_req = 0; l2_gnt = 0;
    while (mq.size() > 0 && guard < 8) begin
      l2_rvalid = 1; l2_rdata = 32'hC0DE0000 + guard;
      cyc();
      guard++;
    end
    l2_rvalid = 0;
    chk("drain_done", mq.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit exp_w;
    ro_req = 0; ro_wen = 1; ro_addr = 0; ro_be = 4'hF; ro_wdata = 0;
    wo_req = 0; wo_wen = 0; wo_addr = 0; wo_be = 4'hF; wo_wdata = 0;
    l2_gnt = 0; l2_rvalid = 0; l2_rdata = 0;
    rst_n = 1;
    #2 rst_n = 0;
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("rst_err", err, 0);
    chk("rst_req", l2_req, 0);
    chk("rst_ro_rvalid", ro_rvalid, 0);
    chk("rst_wo_rvalid", wo_rvalid, 0);
    cyc();

    // single ro read
    ro_req = 1; ro_addr = 32'h1C000000; l2_gnt = 1;
    #1;
    chk("t1_ro_gnt", ro_gnt, 1);
    chk("t1_wo_gnt", wo_gnt, 0);
    chk("t1_addr", l2_addr, 32'h1C000000);
    cyc();
    ro_req = 0; l2_gnt = 0; l2_rvalid = 1; l2_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_ro_rvalid", ro_rvalid, 1);
    chk("t1_ro_rdata", ro_rdata, 32'hDEADBEEF);
    chk("t1_wo_rvalid", wo_rvalid, 0);
    cyc();
    l2_rvalid = 0;
    cyc();

    // both channels requesting continuously
    ro_addr = 32'h1C000000; ro_wen = 1;
    wo_addr = 32'h1C000800; wo_wen = 0;
    ro_req = 1; wo_req = 1; l2_gnt = 1;
    for (int i = 0; i < 8; i++) begin
      wo_wdata = 32'hA5A50000 + i;
      l2_rvalid = (i > 0); l2_rdata = 32'h1000 + i;
`ifdef UDMA_L2_MERGE_RR_EN
      exp_w = (i % 2 == 1);
`else
      exp_w = 1'b1;
`endif
      #1;
      chk("arb_wo_gnt", wo_gnt, exp_w);
      chk("arb_ro_gnt", ro_gnt, !exp_w);
      cyc();
    end
    drain();

    // push and pop together at count 1, alternating channels
    l2_gnt = 1;
    for (int i = 0; i < 10; i++) begin
      ro_req = (i % 2 == 0); wo_req = (i % 2 != 0);
      l2_rvalid = (i > 0); l2_rdata = 32'h2000 + i;
      #1;
      chk("pp_req", l2_req, 1);
      if (i > 0) chk("pp_ro_rvalid", ro_rvalid, ((i - 1) % 2 == 0));
      cyc();
    end
    drain();

    // fill to MAX_OUTSTANDING and withhold responses
    ro_req = 1; wo_req = 1; l2_gnt = 1; l2_rvalid = 0;
    cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_req", l2_req, 0);
      chk("full_gnt", ro_gnt | wo_gnt, 0);
      cyc();
    end
    l2_rvalid = 1; l2_rdata = 32'h3000;
    #1;
    chk("full_req_pop", l2_req, 0);
`ifdef UDMA_L2_MERGE_RR_EN
    chk("full_rv1_wo", wo_rvalid, 0);
`else
    chk("full_rv1_wo", wo_rvalid, 1);
`endif
    cyc();
    l2_rdata = 32'h3001;
    #1;
    chk("full_rv2_wo", wo_rvalid, 1);
    chk("resume_req", l2_req, 1);
    cyc();
    drain();
    cyc();

    // stray response with empty FIFO
    l2_rvalid = 1; l2_rdata = 32'h4444;
    #1;
    chk("stray_ro_rv", ro_rvalid, 0);
    chk("stray_wo_rv", wo_rvalid, 0);
    chk("stray_err_pre", err, 0);
    cyc();
    l2_rvalid = 0;
    #1;
    chk("stray_err", err, 1);
    repeat (3) cyc();
    chk("stray_err_sticky", err, 1);

    // reset with two outstanding
    ro_req = 1; wo_req = 1; l2_gnt = 1;
    cyc(); cyc();
    ro_req = 0; wo_req = 0; l2_gnt = 0;
    rst_n = 0;
    #1;
    chk("rst2_err", err, 0);
    cyc(); cyc();
    rst_n = 1;
    ro_req = 1; ro_wen = 1; ro_addr = 32'h1C000004; l2_gnt = 1;
    #1;
    chk("rst2_req", l2_req, 1);
    chk("rst2_ro_gnt", ro_gnt, 1);
    cyc();
    ro_req = 0; l2_gnt = 0; l2_rvalid = 1; l2_rdata = 32'h12345678;
    #1;
    chk("rst2_ro_rvalid", ro_rvalid, 1);
    chk("rst2_ro_rdata", ro_rdata, 32'h12345678);
    cyc();
    l2_rvalid = 0;
    #1;
    chk("rst2_err_after", err, 0);
    cyc();

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
